// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters (fetch, loader)
// and the single-port program memory.
interface imem_arbiter_if #(
    parameter int counter_width = 32,
    parameter int word_width    = 32
);
    logic                     f_req;
    logic [counter_width-1:0] f_addr;
    logic                     f_gnt;
    logic [word_width-1:0]    f_instr;

    logic                     l_req;
    logic [counter_width-1:0] l_addr;
    logic [word_width-1:0]    l_wdata;
    logic                     l_last;
    logic                     l_gnt;
    logic                     l_done;

    logic                     mem_we;
    logic [counter_width-1:0] mem_addr;
    logic [word_width-1:0]    mem_wdata;
    logic [word_width-1:0]    mem_rd_data;

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, l_last, mem_rd_data,
        output f_gnt, f_instr, l_gnt, l_done, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, l_last, mem_rd_data,
        input  f_gnt, f_instr, l_gnt, l_done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port program memory between fetch reads and bounded loader write bursts.
// Defining IMEM_ARB_PERF_EN adds the saturating fetch-stall counter output fstall_cnt.
module imem_arbiter #(
    parameter int counter_width = 32,
    parameter int word_width    = 32,
    parameter int max_burst     = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]   fstall_cnt
`endif
);

    typedef enum logic {FETCH, LOAD} owner_e;

    localparam logic [7:0] LastBeat = 8'(max_burst - 1);

    owner_e                   owner_q, owner_d;
    logic [7:0]               bcnt_q, bcnt_d;
    logic                     l_done_q, l_done_d;
    logic                     f_gnt, l_gnt, burst_end;
    logic [counter_width-1:0] addr_mux;
    logic [word_width-1:0]    rd_data;

    always_comb begin
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        owner_d   = owner_q;
        bcnt_d    = bcnt_q;
        burst_end = bus.l_last || (bcnt_q == LastBeat);

        case (owner_q)
            FETCH: begin
                if (bus.f_req) begin
                    f_gnt   = 1'b1;
                    owner_d = bus.l_req ? LOAD : FETCH;
                    bcnt_d  = 8'd0;
                end else if (bus.l_req) begin
                    l_gnt = 1'b1;
                end
            end
            LOAD: begin
                if (bus.l_req) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt   = bus.f_req;
                    owner_d = FETCH;
                    bcnt_d  = 8'd0;
                end
            end
            default: begin
                owner_d = FETCH;
                bcnt_d  = 8'd0;
            end
        endcase

        // A beat taken directly from FETCH counts as the first beat of the burst.
        if (l_gnt) begin
            if (burst_end) begin
                owner_d = FETCH;
                bcnt_d  = 8'd0;
            end else begin
                owner_d = LOAD;
                bcnt_d  = bcnt_q + 8'd1;
            end
        end

        l_done_d = l_gnt && bus.l_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= FETCH;
            bcnt_q   <= 8'd0;
            l_done_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            bcnt_q   <= bcnt_d;
            l_done_q <= l_done_d;
        end
    end

    assign addr_mux      = l_gnt ? bus.l_addr : bus.f_addr;
    assign rd_data       = bus.mem_rd_data;
    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.l_done    = l_done_q;
    assign bus.mem_we    = l_gnt;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = bus.l_wdata;
    assign bus.f_instr   = rd_data;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] fstall_q, fstall_d;

    always_comb begin
        fstall_d = fstall_q;
        if (bus.f_req && !f_gnt && (fstall_q != 32'hFFFF_FFFF)) begin
            fstall_d = fstall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstall_q <= 32'd0;
        end else begin
            fstall_q <= fstall_d;
        end
    end

    assign fstall_cnt = fstall_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed scenarios plus random traffic against a
// request-level reference model; fstall_cnt is checked when IMEM_ARB_PERF_EN is defined.
module tb_imem_arbiter;

    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_arbiter_if #(.counter_width(32), .word_width(32)) bus ();

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] fstall_cnt;
`endif

    imem_arbiter #(
        .counter_width(32),
        .word_width   (32),
        .max_burst    (MAX_BURST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef IMEM_ARB_PERF_EN
        ,
        .fstall_cnt(fstall_cnt)
`endif
    );

    typedef struct {
        logic        f_gnt;
        logic        l_gnt;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] f_instr;
        logic        l_done;
        logic [31:0] fstall;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem[64];
    logic [31:0] ref_mem[64];

    // Reference model: loader priority, beats in the current burst, pending l_done, stall count.
    bit          loader_prio;
    int          beats_in_burst;
    bit          done_pending;
    logic [31:0] stall_count;

    assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_cycle(input bit rst, input bit fr, input logic [31:0] fa,
                               input bit lr, input logic [31:0] la, input logic [31:0] lw,
                               input bit ll);
        exp_t e;
        bit   gl, gf, fin;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.l_req   = lr;
        bus.l_addr  = la;
        bus.l_wdata = lw;
        bus.l_last  = ll;

        if (rst) begin
            loader_prio    = 1'b0;
            beats_in_burst = 0;
            done_pending   = 1'b0;
            stall_count    = 32'd0;
        end

        gl          = lr && (loader_prio || !fr);
        gf          = fr && !gl;
        e.f_gnt     = gf;
        e.l_gnt     = gl;
        e.mem_we    = gl;
        e.mem_addr  = gl ? la : fa;
        e.mem_wdata = lw;
        e.f_instr   = ref_mem[fa[7:2]];
        e.l_done    = done_pending;
        e.fstall    = stall_count;
        exp_q.push_back(e);

        if (gl) ref_mem[la[7:2]] = lw;

        if (!rst) begin
            done_pending = gl && ll;
            if (fr && !gf && stall_count != 32'hFFFF_FFFF) stall_count++;
            if (gl) begin
                beats_in_burst++;
                fin         = ll || (beats_in_burst == MAX_BURST);
                loader_prio = !fin;
                if (fin) beats_in_burst = 0;
            end else begin
                loader_prio    = gf && lr;
                beats_in_burst = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("f_gnt", 32'(bus.f_gnt), 32'(mon_e.f_gnt));
            check("l_gnt", 32'(bus.l_gnt), 32'(mon_e.l_gnt));
            check("mem_we", 32'(bus.mem_we), 32'(mon_e.mem_we));
            check("mem_addr", bus.mem_addr, mon_e.mem_addr);
            check("mem_wdata", bus.mem_wdata, mon_e.mem_wdata);
            check("l_done", 32'(bus.l_done), 32'(mon_e.l_done));
            if (mon_e.f_gnt) check("f_instr", bus.f_instr, mon_e.f_instr);
`ifdef IMEM_ARB_PERF_EN
            check("fstall_cnt", fstall_cnt, mon_e.fstall);
`endif
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        loader_prio    = 1'b0;
        beats_in_burst = 0;
        done_pending   = 1'b0;
        stall_count    = 32'd0;
        reset          = 1'b1;
        bus.f_req      = 1'b0;
        bus.f_addr     = 32'd0;
        bus.l_req      = 1'b0;
        bus.l_addr     = 32'd0;
        bus.l_wdata    = 32'd0;
        bus.l_last     = 1'b0;

        apply_cycle(1, 0, 0, 0, 0, 0, 0);
        apply_cycle(1, 1, 32'h10, 0, 0, 0, 0);

        // Single fetch after reset.
        apply_cycle(0, 1, 32'h10, 0, 0, 0, 0);

        // Three-beat loader burst, then l_done and read-back.
        apply_cycle(0, 0, 0, 1, 32'h0, 32'hA000_0001, 0);
        apply_cycle(0, 0, 0, 1, 32'h4, 32'hA000_0002, 0);
        apply_cycle(0, 0, 0, 1, 32'h8, 32'hA000_0003, 1);
        apply_cycle(0, 0, 0, 0, 0, 0, 0);
        apply_cycle(0, 1, 32'h0, 0, 0, 0, 0);
        apply_cycle(0, 1, 32'h4, 0, 0, 0, 0);
        apply_cycle(0, 1, 32'h8, 0, 0, 0, 0);

        // Both requesters held: fetch, max_burst loads, fetch, ...
        apply_cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            apply_cycle(0, 1, 32'h8, 1, 32'(4 * (i % 16) + 32'h40), 32'hB000_0000 + 32'(i), 0);
`ifdef IMEM_ARB_PERF_EN
            if (i == 18) check("fstall_after_18", fstall_cnt, 32'd16);
`endif
        end

        // Loader drops l_req while fetch waits: fetch granted in the same cycle.
        apply_cycle(1, 0, 0, 0, 0, 0, 0);
        apply_cycle(0, 0, 32'h40, 1, 32'h80, 32'hC000_0001, 0);
        apply_cycle(0, 1, 32'h40, 1, 32'h84, 32'hC000_0002, 0);
        apply_cycle(0, 1, 32'h80, 0, 32'h88, 32'hC000_0003, 0);

        // Reset asserted between edges at beat 5 of a burst.
        apply_cycle(1, 0, 0, 0, 0, 0, 0);
        apply_cycle(0, 1, 32'h84, 1, 32'h90, 32'hD000_0000, 0);
        for (int i = 1; i <= 4; i++)
            apply_cycle(0, 1, 32'h84, 1, 32'h90 + 32'(4 * i), 32'hD000_0000 + 32'(i), 0);
        apply_cycle(1, 1, 32'h84, 1, 32'hA4, 32'hD000_0005, 1);
        apply_cycle(0, 1, 32'h94, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            apply_cycle($urandom_range(0, 149) == 0,
                        $urandom_range(0, 3) != 0,
                        32'($urandom_range(0, 63)) << 2,
                        $urandom_range(0, 2) != 0,
                        32'($urandom_range(0, 63)) << 2,
                        $urandom,
                        $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
